ex_operand_stage: RTL and testbench

//  ID/EX pipeline register plus forwarding, directly upstream of the ALU.
//  - Captures decoded operands and control from ID; drives ALU control, a and b.
//  - Resolves RAW hazards from EX/MEM and MEM/WB by forwarding.
//  - Detects load-use hazards and inserts a bubble.

---
 rtl/ve370_pkg.sv | 22 ++
 rtl/forward_unit.sv | 47 ++++
 rtl/ex_operand_stage.sv | 143 ++++++++++++++
 tb/tb_ex_operand_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ve370_pkg.sv
// Shared constants and types for the EX operand stage: datapath widths,
// ALU operation codes and the forwarding source selector.
package ve370_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int CTRL_W = 4;

    localparam logic [CTRL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [CTRL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [CTRL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [CTRL_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [CTRL_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [CTRL_W-1:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/forward_unit.sv
// Combinational operand forwarding for one source register. The youngest
// producer (EX/MEM) wins over MEM/WB; register $0 is never forwarded.
module forward_unit #(
    parameter int DATA_W = ve370_pkg::DATA_W,
    parameter int REG_AW = ve370_pkg::REG_AW
) (
    input  logic [REG_AW-1:0] i_src,
    input  logic [DATA_W-1:0] i_reg_data,
    input  logic              i_exmem_reg_write,
    input  logic [REG_AW-1:0] i_exmem_rd,
    input  logic [DATA_W-1:0] i_exmem_result,
    input  logic              i_memwb_reg_write,
    input  logic [REG_AW-1:0] i_memwb_rd,
    input  logic [DATA_W-1:0] i_memwb_result,
    output logic [DATA_W-1:0] o_data
);
    import ve370_pkg::*;

    fwd_sel_e w_sel;
    logic     w_src_nz;

    assign w_src_nz = (i_src != {REG_AW{1'b0}});

    // Pick the forwarding source; bubbles never match because their reg_write is 0.
    always_comb begin
        w_sel = FWD_REG;
        if (w_src_nz && i_exmem_reg_write && (i_exmem_rd == i_src)) begin
            w_sel = FWD_EXMEM;
        end else if (w_src_nz && i_memwb_reg_write && (i_memwb_rd == i_src)) begin
            w_sel = FWD_MEMWB;
        end else begin
            w_sel = FWD_REG;
        end
    end

    // Steer the selected value onto the operand.
    always_comb begin
        o_data = i_reg_data;
        case (w_sel)
            FWD_EXMEM: o_data = i_exmem_result;
            FWD_MEMWB: o_data = i_memwb_result;
            FWD_REG:   o_data = i_reg_data;
            default:   o_data = i_reg_data;
        endcase
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with RAW forwarding into the ALU operands and
// load-use hazard detection that turns the next EX slot into a bubble.
module ex_operand_stage #(
    parameter int DATA_W = ve370_pkg::DATA_W,
    parameter int REG_AW = ve370_pkg::REG_AW,
    parameter int CTRL_W = ve370_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [CTRL_W-1:0] id_alu_ctrl,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              hold,
    input  logic              flush,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic              load_use_stall,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_dest,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg
);
    import ve370_pkg::*;

    logic              r_valid;
    logic              r_reg_write;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_mem_to_reg;
    logic              r_alu_src;
    logic [CTRL_W-1:0] r_alu_ctrl;
    logic [REG_AW-1:0] r_rs;
    logic [REG_AW-1:0] r_rt;
    logic [REG_AW-1:0] r_dest;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;

    logic              w_load_use;
    logic              w_bubble;
    logic [DATA_W-1:0] w_fwd_rs;
    logic [DATA_W-1:0] w_fwd_rt;

    // A load in EX whose destination feeds the instruction in ID must wait one cycle.
    // Both rs and rt are compared even if ID does not read rt (conservative).
    assign w_load_use = r_valid && r_mem_read && id_valid &&
                        (r_dest != {REG_AW{1'b0}}) &&
                        ((r_dest == id_rs) || (r_dest == id_rt));

    // Flush beats hold; a load-use bubble only lands when the stage is not frozen.
    assign w_bubble = flush || (!hold && w_load_use);

    // Pipeline register: reset/bubble clear everything, hold freezes, else capture ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || w_bubble) begin
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_alu_src    <= 1'b0;
            r_alu_ctrl   <= {CTRL_W{1'b0}};
            r_rs         <= {REG_AW{1'b0}};
            r_rt         <= {REG_AW{1'b0}};
            r_dest       <= {REG_AW{1'b0}};
            r_rs_data    <= {DATA_W{1'b0}};
            r_rt_data    <= {DATA_W{1'b0}};
            r_imm        <= {DATA_W{1'b0}};
        end else if (!hold) begin
            r_valid      <= id_valid;
            r_reg_write  <= id_reg_write;
            r_mem_read   <= id_mem_read;
            r_mem_write  <= id_mem_write;
            r_mem_to_reg <= id_mem_to_reg;
            r_alu_src    <= id_alu_src;
            r_alu_ctrl   <= id_alu_ctrl;
            r_rs         <= id_rs;
            r_rt         <= id_rt;
            r_dest       <= id_reg_dst ? id_rd : id_rt;
            r_rs_data    <= id_rs_data;
            r_rt_data    <= id_rt_data;
            r_imm        <= id_imm;
        end
    end

    forward_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .i_src             (r_rs),
        .i_reg_data        (r_rs_data),
        .i_exmem_reg_write (exmem_reg_write),
        .i_exmem_rd        (exmem_rd),
        .i_exmem_result    (exmem_result),
        .i_memwb_reg_write (memwb_reg_write),
        .i_memwb_rd        (memwb_rd),
        .i_memwb_result    (memwb_result),
        .o_data            (w_fwd_rs)
    );

    forward_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .i_src             (r_rt),
        .i_reg_data        (r_rt_data),
        .i_exmem_reg_write (exmem_reg_write),
        .i_exmem_rd        (exmem_rd),
        .i_exmem_result    (exmem_result),
        .i_memwb_reg_write (memwb_reg_write),
        .i_memwb_rd        (memwb_rd),
        .i_memwb_result    (memwb_result),
        .o_data            (w_fwd_rt)
    );

    assign load_use_stall = w_load_use;
    assign alu_ctrl       = r_alu_ctrl;
    assign alu_a          = w_fwd_rs;
    assign alu_b          = r_alu_src ? r_imm : w_fwd_rt;
    assign ex_store_data  = w_fwd_rt;
    assign ex_dest        = r_dest;
    assign ex_valid       = r_valid;
    assign ex_reg_write   = r_reg_write;
    assign ex_mem_read    = r_mem_read;
    assign ex_mem_write   = r_mem_write;
    assign ex_mem_to_reg  = r_mem_to_reg;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed scenarios followed by random traffic,
// all checked against a cycle-level reference model of the stage.
module tb_ex_operand_stage;
    import ve370_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_alu_src, id_reg_dst;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [3:0]  id_alu_ctrl;
    logic        hold, flush;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;

    logic        load_use_stall;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [4:0]  ex_dest;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: contents of the ID/EX slot as the instruction sees it.
    typedef struct packed {
        logic        valid, rw, mr, mw, m2r, alu_src;
        logic [3:0]  ctrl;
        logic [4:0]  rs, rt, dest;
        logic [31:0] rsd, rtd, imm;
    } slot_t;
    slot_t m;

    always #5 clk = ~clk;

    ex_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_alu_ctrl(id_alu_ctrl),
        .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .hold(hold), .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .load_use_stall(load_use_stall), .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Value an EX instruction reads for one source, given the producers downstream.
    function automatic logic [31:0] ref_fwd(input logic [4:0] src, input logic [31:0] regv);
        if (src == 5'd0) return regv;
        if (exmem_reg_write && exmem_rd == src) return exmem_result;
        if (memwb_reg_write && memwb_rd == src) return memwb_result;
        return regv;
    endfunction

    function automatic logic ref_stall();
        return m.valid && m.mr && id_valid && (m.dest != 5'd0) &&
               (m.dest == id_rs || m.dest == id_rt);
    endfunction

    task automatic check_all();
        logic [31:0] frt;
        frt = ref_fwd(m.rt, m.rtd);
        chk("stall", 32'(load_use_stall), 32'(ref_stall()));
        chk("alu_ctrl", 32'(alu_ctrl), 32'(m.ctrl));
        chk("alu_a", alu_a, ref_fwd(m.rs, m.rsd));
        chk("alu_b", alu_b, m.alu_src ? m.imm : frt);
        chk("store_data", ex_store_data, frt);
        chk("ex_dest", 32'(ex_dest), 32'(m.dest));
        chk("ex_valid", 32'(ex_valid), 32'(m.valid));
        chk("reg_write", 32'(ex_reg_write), 32'(m.rw));
        chk("mem_read", 32'(ex_mem_read), 32'(m.mr));
        chk("mem_write", 32'(ex_mem_write), 32'(m.mw));
        chk("mem_to_reg", 32'(ex_mem_to_reg), 32'(m.m2r));
    endtask

    // Advance the model by one rising edge using the inputs present before it.
    task automatic model_edge(input logic stall);
        if (!rst_n || flush) m = '0;
        else if (hold) m = m;
        else if (stall) m = '0;
        else begin
            m.valid = id_valid; m.rw = id_reg_write; m.mr = id_mem_read;
            m.mw = id_mem_write; m.m2r = id_mem_to_reg; m.alu_src = id_alu_src;
            m.ctrl = id_alu_ctrl; m.rs = id_rs; m.rt = id_rt;
            m.dest = id_reg_dst ? id_rd : id_rt;
            m.rsd = id_rs_data; m.rtd = id_rt_data; m.imm = id_imm;
        end
    endtask

    task automatic tick();
        logic st;
        #1 check_all();
        st = ref_stall();
        @(posedge clk);
        model_edge(st);
        #1 check_all();
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [31:0] imm, input logic [3:0] ctrl, input logic asrc,
                          input logic rdst, input logic rw, input logic mr, input logic mw,
                          input logic m2r);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_alu_ctrl = ctrl;
        id_alu_src = asrc; id_reg_dst = rdst; id_reg_write = rw;
        id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r;
    endtask

    task automatic clr_fwd();
        exmem_reg_write = 1'b0; exmem_rd = 5'd0; exmem_result = 32'd0;
        memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_result = 32'd0;
    endtask

    task automatic rand_id();
        set_id(($urandom_range(0, 9) < 8), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), $urandom(), $urandom(), $urandom(),
               4'($urandom()), 1'($urandom()), 1'($urandom()), 1'($urandom()),
               1'($urandom()), 1'($urandom()), 1'($urandom()));
    endtask

    logic [31:0] sv_a, sv_b;
    logic [4:0]  sv_dest;
    logic [3:0]  sv_ctrl;

    initial begin
        // Reset state
        rst_n = 1'b0; hold = 1'b0; flush = 1'b0; m = '0;
        clr_fwd();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 4'd0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #3 check_all();
        @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

        // Capture: add $3,$1,$2 with rs=5, rt=7
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, ALU_ADD,
               1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("cap_a", alu_a, 32'd5);
        chk("cap_b", alu_b, 32'd7);
        chk("cap_ctrl", 32'(alu_ctrl), 32'h2);
        chk("cap_dest", 32'(ex_dest), 32'd3);

        // Double forward on rs=1, then only MEM/WB matches
        exmem_reg_write = 1'b1; exmem_rd = 5'd1; exmem_result = 32'd10;
        memwb_reg_write = 1'b1; memwb_rd = 5'd1; memwb_result = 32'd20;
        #1 chk("fwd_both", alu_a, 32'd10);
        exmem_rd = 5'd6;
        #1 chk("fwd_memwb", alu_a, 32'd20);
        check_all();

        // Source $0 never forwards
        clr_fwd();
        set_id(1'b1, 5'd0, 5'd2, 5'd3, 32'h99, 32'd7, 32'd0, ALU_OR,
               1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        exmem_reg_write = 1'b1; exmem_rd = 5'd0; exmem_result = 32'd10;
        memwb_reg_write = 1'b1; memwb_rd = 5'd0; memwb_result = 32'd20;
        #1 chk("fwd_r0", alu_a, 32'h99);

        // Load-use: lw $4 in EX, ID reads $4
        clr_fwd();
        set_id(1'b1, 5'd1, 5'd4, 5'd0, 32'd100, 32'd0, 32'd8, ALU_ADD,
               1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        chk("lw_dest", 32'(ex_dest), 32'd4);
        set_id(1'b1, 5'd4, 5'd6, 5'd8, 32'h44, 32'h66, 32'd0, ALU_SUB,
               1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 chk("lu_stall", 32'(load_use_stall), 32'd1);
        tick();
        chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
        chk("lu_bubble_stall", 32'(load_use_stall), 32'd0);
        tick();
        chk("lu_after_valid", 32'(ex_valid), 32'd1);
        chk("lu_after_a", alu_a, 32'h44);

        // Hold for 3 cycles while ID changes
        sv_a = alu_a; sv_b = alu_b; sv_dest = ex_dest; sv_ctrl = alu_ctrl;
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_id();
            tick();
            chk("hold_a", alu_a, sv_a);
            chk("hold_b", alu_b, sv_b);
            chk("hold_dest", 32'(ex_dest), 32'(sv_dest));
            chk("hold_ctrl", 32'(alu_ctrl), 32'(sv_ctrl));
        end
        flush = 1'b1;
        tick();
        chk("flush_hold_valid", 32'(ex_valid), 32'd0);
        chk("flush_hold_rw", 32'(ex_reg_write), 32'd0);
        flush = 1'b0; hold = 1'b0;

        // Immediate operand with forwarded rt for a store
        set_id(1'b1, 5'd2, 5'd3, 5'd9, 32'd1, 32'd2, 32'hFFFF_FFFC, ALU_ADD,
               1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        exmem_reg_write = 1'b1; exmem_rd = 5'd3; exmem_result = 32'h1234;
        #1 chk("imm_b", alu_b, 32'hFFFF_FFFC);
        chk("imm_store", ex_store_data, 32'h1234);

        // Async reset in the middle of a load-use stall
        clr_fwd();
        set_id(1'b1, 5'd1, 5'd5, 5'd0, 32'd3, 32'd0, 32'd4, ALU_ADD,
               1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        set_id(1'b1, 5'd5, 5'd2, 5'd7, 32'h55, 32'h22, 32'd0, ALU_AND,
               1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 chk("rst_pre_stall", 32'(load_use_stall), 32'd1);
        #2 rst_n = 1'b0; m = '0;
        #1 chk("rst_async_valid", 32'(ex_valid), 32'd0);
        chk("rst_async_stall", 32'(load_use_stall), 32'd0);
        check_all();
        @(posedge clk); #1 rst_n = 1'b1;
        tick();
        chk("rst_release_valid", 32'(ex_valid), 32'd1);
        chk("rst_release_a", alu_a, 32'h55);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            rand_id();
            hold = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 9) == 0);
            exmem_reg_write = 1'($urandom()); exmem_rd = 5'($urandom_range(0, 7));
            exmem_result = $urandom();
            memwb_reg_write = 1'($urandom()); memwb_rd = 5'($urandom_range(0, 7));
            memwb_result = $urandom();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
